// File: rtl/object_encoder_if.sv
// Point-in / object-out bundle for object_encoder.
// Point side: pt_* endpoint stream with valid/ready plus abort.
// Object side: packed object record with valid/ready and a reserved-shape error pulse.
interface object_encoder_if;
    logic [10:0] pt_x_in;
    logic [9:0]  pt_y_in;
    logic [1:0]  shape_in;
    logic        is_static_in;
    logic        pt_valid_in;
    logic        pt_ready_out;
    logic        abort_in;
    logic [15:0] pos_x_out;
    logic [15:0] pos_y_out;
    logic [47:0] params_out;
    logic [1:0]  shape_out;
    logic        is_static_out;
    logic        obj_valid_out;
    logic        obj_ready_in;
    logic        error_out;

    // Encoder side
    modport slave (
        input  pt_x_in, pt_y_in, shape_in, is_static_in, pt_valid_in, abort_in, obj_ready_in,
        output pt_ready_out, pos_x_out, pos_y_out, params_out, shape_out, is_static_out,
        output obj_valid_out, error_out
    );

    // Producer / consumer side
    modport master (
        output pt_x_in, pt_y_in, shape_in, is_static_in, pt_valid_in, abort_in, obj_ready_in,
        input  pt_ready_out, pos_x_out, pos_y_out, params_out, shape_out, is_static_out,
        input  obj_valid_out, error_out
    );
endinterface

// File: rtl/object_encoder.sv
// Packs two clamped screen endpoints plus a shape type into an object record (pos_x, pos_y, params).
// Latency: second endpoint accepted -> one CALC cycle -> object held valid in OUT until obj_ready_in.
// Backpressure: pt_ready_out is low in CALC/OUT, so no new endpoints are taken while an object is pending.
// Ports: clk_in/rst_in (async active-high), bus = object_encoder_if.slave (point stream in, object stream out).
module object_encoder #(
    parameter int SCALE = 6,
    parameter int X_MAX = 1279,
    parameter int Y_MAX = 719
) (
    input  logic               clk_in,
    input  logic               rst_in,
    object_encoder_if.slave    bus
);
    localparam logic [10:0] X_LIM = 11'(X_MAX);
    localparam logic [9:0]  Y_LIM = 10'(Y_MAX);

    typedef enum logic [1:0] {WAIT_P1, WAIT_P2, CALC, OUT} state_t;
    state_t state, state_nxt;

    logic        pt_ready;
    logic [10:0] x_cl, x1, x2;
    logic [9:0]  y_cl, y1, y2;
    logic [1:0]  shp;
    logic        st;
    logic        err_q;
    logic [15:0] pos_x_q, pos_y_q;
    logic [47:0] params_q;
    logic [1:0]  shape_q;
    logic        static_q;

    // Ready is asserted in both point-waiting states, so the handshake reduces to pt_valid_in there.
    logic p1_take, p2_take, p1_reserved;
    assign p1_take     = (state == WAIT_P1) && bus.pt_valid_in;
    assign p1_reserved = p1_take && (bus.shape_in == 2'd3);
    // Abort wins over a coincident second point.
    assign p2_take     = (state == WAIT_P2) && bus.pt_valid_in && !bus.abort_in;

    assign x_cl = (bus.pt_x_in > X_LIM) ? X_LIM : bus.pt_x_in;
    assign y_cl = (bus.pt_y_in > Y_LIM) ? Y_LIM : bus.pt_y_in;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= WAIT_P1;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pt_ready  = 1'b0;
        case (state)
            WAIT_P1: begin
                pt_ready = 1'b1;
                if (p1_take && !p1_reserved) state_nxt = WAIT_P2;
            end
            WAIT_P2: begin
                pt_ready = 1'b1;
                if (bus.abort_in)  state_nxt = WAIT_P1;
                else if (p2_take)  state_nxt = CALC;
            end
            CALC: state_nxt = OUT;
            OUT:  if (bus.obj_ready_in) state_nxt = WAIT_P1;
            default: state_nxt = WAIT_P1;
        endcase
    end

    // Packing arithmetic: 17-bit signed, truncated to 16 on output.
    logic signed [16:0] sx1, sx2, sy1, sy2, dx, dy, adx, sumx, sumy;
    logic [15:0]        calc_pos_x, calc_pos_y;
    logic [47:0]        calc_params;

    assign sx1  = $signed({6'd0, x1});
    assign sx2  = $signed({6'd0, x2});
    assign sy1  = $signed({7'd0, y1});
    assign sy2  = $signed({7'd0, y2});
    assign dx   = sx2 - sx1;
    assign dy   = sy2 - sy1;
    assign adx  = dx[16] ? -dx : dx;
    assign sumx = sx1 + sx2;
    assign sumy = sy1 + sy2;

    always_comb begin
        calc_pos_x  = {5'd0, x1};
        calc_pos_y  = {6'd0, y1};
        calc_params = {16'd0, 5'd0, x2, 6'd0, y2};
        case (shp)
            2'd0: begin
                // Centre is the midpoint in fixed point: (a+b)/2 << SCALE == (a+b) << (SCALE-1).
                calc_pos_x  = 16'(sumx <<< (SCALE - 1));
                calc_pos_y  = 16'(sumy <<< (SCALE - 1));
                calc_params = {32'd0, 16'(adx <<< (SCALE - 1))};
            end
            2'd1: calc_params = {dx[15:0], dy[15:0], 16'd0};
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            x1 <= '0; y1 <= '0; x2 <= '0; y2 <= '0;
            shp <= '0; st <= 1'b0; err_q <= 1'b0;
            pos_x_q <= '0; pos_y_q <= '0; params_q <= '0;
            shape_q <= '0; static_q <= 1'b0;
        end else begin
            err_q <= p1_reserved;
            if (p1_take && !p1_reserved) begin
                x1  <= x_cl;
                y1  <= y_cl;
                shp <= bus.shape_in;
                st  <= bus.is_static_in;
            end
            if (p2_take) begin
                x2 <= x_cl;
                y2 <= y_cl;
            end
            if (state == CALC) begin
                pos_x_q  <= calc_pos_x;
                pos_y_q  <= calc_pos_y;
                params_q <= calc_params;
                shape_q  <= shp;
                static_q <= st;
            end
        end
    end

    assign bus.pt_ready_out  = pt_ready;
    assign bus.obj_valid_out = (state == OUT);
    assign bus.error_out     = err_q;
    assign bus.pos_x_out     = pos_x_q;
    assign bus.pos_y_out     = pos_y_q;
    assign bus.params_out    = params_q;
    assign bus.shape_out     = shape_q;
    assign bus.is_static_out = static_q;
endmodule

// File: tb/tb_object_encoder.sv
// Directed bench for object_encoder: table of endpoint pairs with expected packed records,
// plus sequences for reserved shape, backpressure, abort and asynchronous reset.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_object_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    object_encoder_if bus();

    object_encoder dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_pt(input logic [10:0] x, input logic [9:0] y,
                           input logic [1:0] s, input logic stat);
        bus.pt_x_in      = x;
        bus.pt_y_in      = y;
        bus.shape_in     = s;
        bus.is_static_in = stat;
        bus.pt_valid_in  = 1'b1;
        @(posedge clk); #1;
        bus.pt_valid_in  = 1'b0;
    endtask

    task automatic wait_obj(output bit got);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.obj_valid_out) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic accept_obj();
        bus.obj_ready_in = 1'b1;
        @(posedge clk); #1;
        bus.obj_ready_in = 1'b0;
        chk("valid_drop", bus.obj_valid_out, 0);
        chk("ready_back", bus.pt_ready_out, 1);
    endtask

    typedef struct {
        logic [10:0] x1; logic [9:0] y1;
        logic [10:0] x2; logic [9:0] y2;
        logic [1:0]  shape; logic stat;
        logic [15:0] px; logic [15:0] py; logic [47:0] prm;
    } vec_t;

    vec_t vt[7];
    bit   got;
    bit   seen;

    initial begin
        // circle and its swapped twin must encode identically
        vt[0] = '{100, 50, 140, 50, 2'd0, 1'b0, 16'd7680, 16'd3200, {32'd0, 16'd1280}};
        vt[1] = '{140, 50, 100, 50, 2'd0, 1'b0, 16'd7680, 16'd3200, {32'd0, 16'd1280}};
        vt[2] = '{10, 20, 30, 60, 2'd1, 1'b0, 16'd10, 16'd20, {16'd20, 16'd40, 16'd0}};
        vt[3] = '{5, 6, 2000, 900, 2'd2, 1'b1, 16'd5, 16'd6, {16'd0, 16'd1279, 16'd719}};
        // reversed rect: negative dx=-20, dy=-40
        vt[4] = '{30, 60, 10, 20, 2'd1, 1'b1, 16'd30, 16'd60, {16'hFFEC, 16'hFFD8, 16'd0}};
        // clamped circle: (1279,719),(0,0): 1279*32=40928, 719*32=23008
        vt[5] = '{1300, 800, 0, 0, 2'd0, 1'b1, 16'd40928, 16'd23008, {32'd0, 16'd40928}};
        vt[6] = '{0, 0, 1279, 719, 2'd2, 1'b0, 16'd0, 16'd0, {16'd0, 16'd1279, 16'd719}};

        bus.pt_x_in = '0; bus.pt_y_in = '0; bus.shape_in = '0; bus.is_static_in = 1'b0;
        bus.pt_valid_in = 1'b0; bus.abort_in = 1'b0; bus.obj_ready_in = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus.pt_ready_out, 1);
        chk("rst_valid", bus.obj_valid_out, 0);
        chk("rst_error", bus.error_out, 0);
        chk("rst_pos", {bus.pos_x_out, bus.pos_y_out}, 0);
        chk("rst_params", bus.params_out, 0);
        chk("rst_shape", {bus.shape_out, bus.is_static_out}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            send_pt(vt[i].x1, vt[i].y1, vt[i].shape, vt[i].stat);
            // shape/static on the second point must be ignored
            send_pt(vt[i].x2, vt[i].y2, ~vt[i].shape, ~vt[i].stat);
            chk("calc_no_valid", bus.obj_valid_out, 0);
            chk("calc_not_ready", bus.pt_ready_out, 0);
            wait_obj(got);
            chk("obj_arrived", got, 1);
            chk("pos_x", bus.pos_x_out, vt[i].px);
            chk("pos_y", bus.pos_y_out, vt[i].py);
            chk("params", bus.params_out, vt[i].prm);
            chk("shape", bus.shape_out, vt[i].shape);
            chk("static", bus.is_static_out, vt[i].stat);
            accept_obj();
        end

        // reserved shape: one-cycle error, no object, next pair fine
        send_pt(50, 50, 2'd3, 1'b0);
        chk("err_pulse", bus.error_out, 1);
        chk("err_stay_p1", bus.pt_ready_out, 1);
        @(posedge clk); #1;
        chk("err_one_cycle", bus.error_out, 0);
        chk("err_no_obj", bus.obj_valid_out, 0);
        send_pt(10, 20, 2'd1, 1'b0);
        send_pt(30, 60, 2'd0, 1'b0);
        wait_obj(got);
        chk("err_next_obj", got, 1);
        chk("err_next_params", bus.params_out, {16'd20, 16'd40, 16'd0});
        accept_obj();

        // backpressure: object held for 5 cycles
        send_pt(100, 50, 2'd0, 1'b1);
        send_pt(140, 50, 2'd0, 1'b0);
        wait_obj(got);
        chk("bp_obj", got, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid_held", bus.obj_valid_out, 1);
            chk("bp_not_ready", bus.pt_ready_out, 0);
            chk("bp_pos_held", {bus.pos_x_out, bus.pos_y_out}, {16'd7680, 16'd3200});
        end
        accept_obj();

        // abort in WAIT_P2 beats a coincident point
        send_pt(10, 20, 2'd1, 1'b0);
        bus.abort_in = 1'b1;
        send_pt(999, 999, 2'd1, 1'b0);
        bus.abort_in = 1'b0;
        chk("abort_ready", bus.pt_ready_out, 1);
        chk("abort_no_calc", bus.obj_valid_out, 0);
        send_pt(1, 2, 2'd1, 1'b0);
        send_pt(4, 8, 2'd2, 1'b0);
        wait_obj(got);
        chk("abort_obj", got, 1);
        chk("abort_pos", {bus.pos_x_out, bus.pos_y_out}, {16'd1, 16'd2});
        chk("abort_params", bus.params_out, {16'd3, 16'd6, 16'd0});
        accept_obj();

        // reset in WAIT_P2
        send_pt(300, 300, 2'd2, 1'b1);
        rst = 1'b1; #2;
        chk("rstp2_ready", bus.pt_ready_out, 1);
        chk("rstp2_outs", {bus.pos_x_out, bus.pos_y_out, bus.params_out}, 0);
        rst = 1'b0;
        // a single point after reset must not complete the dropped pair
        @(posedge clk); #1;
        send_pt(7, 8, 2'd1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.obj_valid_out) seen = 1'b1;
        end
        chk("rstp2_no_stale", seen, 0);
        send_pt(9, 12, 2'd1, 1'b0);
        wait_obj(got);
        chk("rstp2_obj", got, 1);
        chk("rstp2_pos", {bus.pos_x_out, bus.pos_y_out}, {16'd7, 16'd8});
        chk("rstp2_params", bus.params_out, {16'd2, 16'd4, 16'd0});
        chk("rstp2_shape", bus.shape_out, 2'd1);
        accept_obj();

        // reset in OUT
        send_pt(100, 50, 2'd0, 1'b1);
        send_pt(140, 50, 2'd0, 1'b0);
        wait_obj(got);
        chk("rstout_obj", got, 1);
        rst = 1'b1; #2;
        chk("rstout_valid", bus.obj_valid_out, 0);
        chk("rstout_outs", {bus.pos_x_out, bus.pos_y_out, bus.params_out}, 0);
        chk("rstout_flags", {bus.shape_out, bus.is_static_out, bus.error_out}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstout_ready", bus.pt_ready_out, 1);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.obj_valid_out) seen = 1'b1;
        end
        chk("rstout_no_stale", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
